// File: rtl/ctrl_pb200.sv
// Sequencer for a second-order IIR section: a fixed seven-step Moore FSM that
// steers a shared multiply-accumulate datapath once per input sample.
module ctrl_pb200 #(
    parameter int NSTEP = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [2:0] controlS,
    output logic [1:0] controlC,
    output logic [2:0] controlZ,
    output logic       en_acum1,
    output logic       en_acum2,
    output logic       en_acum3,
    output logic       en_fk,
    output logic       en_shift,
    output logic       en_yk,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        S4   = 3'd4,
        S5   = 3'd5,
        S6   = 3'd6,
        S7   = 3'd7
    } state_t;

    localparam logic [2:0] LAST_STEP = NSTEP[2:0];

    state_t state_p0;
    state_t state_nxt;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // A start seen while a sample is still being processed is flagged for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else begin
            overrun <= start && (state_p0 != IDLE);
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state_p0)
            IDLE: state_nxt = start ? S1 : IDLE;
            S1, S2, S3, S4, S5, S6, S7: begin
                if (state_p0 == state_t'(LAST_STEP)) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = state_t'(state_p0 + 3'd1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Moore output decode: every control is a function of the registered state only
    always_comb begin
        controlS = 3'b000;
        controlC = 2'b00;
        controlZ = 3'b000;
        en_acum1 = 1'b0;
        en_acum2 = 1'b0;
        en_acum3 = 1'b0;
        en_fk    = 1'b0;
        en_shift = 1'b0;
        en_yk    = 1'b0;
        done     = 1'b0;
        busy     = (state_p0 != IDLE);
        case (state_p0)
            S1: begin
                controlS = 3'b001; controlC = 2'b01; controlZ = 3'b001;
                en_acum1 = 1'b1;
            end
            S2: begin
                controlS = 3'b010; controlC = 2'b10; controlZ = 3'b011;
                en_acum2 = 1'b1;
            end
            S3: begin
                controlZ = 3'b100;
                en_fk    = 1'b1;
            end
            S4: begin
                controlS = 3'b011; controlC = 2'b11;
                en_acum1 = 1'b1;
            end
            S5: begin
                controlS = 3'b100; controlC = 2'b01; controlZ = 3'b011;
                en_acum2 = 1'b1;
            end
            S6: begin
                controlS = 3'b101; controlC = 2'b10; controlZ = 3'b100;
                en_acum3 = 1'b1;
            end
            S7: begin
                controlZ = 3'b101;
                en_yk    = 1'b1;
                en_shift = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_pb200.sv
// Bench for ctrl_pb200: sequence scoreboard per scenario plus a closed-loop
// fixed-point datapath compared against a direct IIR reference.
module tb_ctrl_pb200;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] controlS;
    logic [1:0] controlC;
    logic [2:0] controlZ;
    logic       en_acum1, en_acum2, en_acum3, en_fk, en_shift, en_yk;
    logic       busy, done, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] exp_q[$];
    int          yk_q[$];

    ctrl_pb200 #(.NSTEP(7)) dut (
        .clk(clk), .reset(reset), .start(start),
        .controlS(controlS), .controlC(controlC), .controlZ(controlZ),
        .en_acum1(en_acum1), .en_acum2(en_acum2), .en_acum3(en_acum3),
        .en_fk(en_fk), .en_shift(en_shift), .en_yk(en_yk),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {S,C,Z,acum1,acum2,acum3,fk,yk,shift,busy,done,overrun}
    logic [16:0] act;
    assign act = {controlS, controlC, controlZ, en_acum1, en_acum2, en_acum3,
                  en_fk, en_yk, en_shift, busy, done, overrun};

    function automatic logic [16:0] exp_vec(input int st, input logic ov);
        logic [15:0] v;
        case (st)
            1:       v = {3'b001, 2'b01, 3'b001, 6'b100000, 1'b1, 1'b0};
            2:       v = {3'b010, 2'b10, 3'b011, 6'b010000, 1'b1, 1'b0};
            3:       v = {3'b000, 2'b00, 3'b100, 6'b000100, 1'b1, 1'b0};
            4:       v = {3'b011, 2'b11, 3'b000, 6'b100000, 1'b1, 1'b0};
            5:       v = {3'b100, 2'b01, 3'b011, 6'b010000, 1'b1, 1'b0};
            6:       v = {3'b101, 2'b10, 3'b100, 6'b001000, 1'b1, 1'b0};
            7:       v = {3'b000, 2'b00, 3'b101, 6'b000011, 1'b1, 1'b1};
            default: v = 16'h0000;
        endcase
        return {v, ov};
    endfunction

    // Behavioural datapath driven by the controller, Q14 coefficients
    int a1 = 8192, a2 = -4096, b0 = 4096, b1 = 8192, b2 = 4096;
    int uk = 16384;
    logic dp_clr = 1'b0;
    int dp_acum1, dp_acum2, dp_acum3, dp_fk, dp_fk1, dp_fk2, dp_yk;
    int dp_s, dp_c, dp_z, dp_sum;

    function automatic int q14(input int c, input int v);
        longint p;
        p = longint'(c) * longint'(v);
        return int'(p >>> 14);
    endfunction

    always_comb begin
        dp_s = 0;
        dp_c = 0;
        dp_z = 0;
        case (controlS)
            3'b001: dp_s = a1;
            3'b010: dp_s = a2;
            3'b011: dp_s = b0;
            3'b100: dp_s = b1;
            3'b101: dp_s = b2;
            default: dp_s = 0;
        endcase
        case (controlC)
            2'b01: dp_c = dp_fk1;
            2'b10: dp_c = dp_fk2;
            2'b11: dp_c = dp_fk;
            default: dp_c = 0;
        endcase
        case (controlZ)
            3'b001: dp_z = uk;
            3'b010: dp_z = dp_yk;
            3'b011: dp_z = dp_acum1;
            3'b100: dp_z = dp_acum2;
            3'b101: dp_z = dp_acum3;
            default: dp_z = 0;
        endcase
        dp_sum = q14(dp_s, dp_c) + dp_z;
    end

    always_ff @(posedge clk) begin
        if (dp_clr) begin
            dp_acum1 <= 0; dp_acum2 <= 0; dp_acum3 <= 0;
            dp_fk <= 0; dp_fk1 <= 0; dp_fk2 <= 0; dp_yk <= 0;
        end else begin
            if (en_acum1) dp_acum1 <= dp_sum;
            if (en_acum2) dp_acum2 <= dp_sum;
            if (en_acum3) dp_acum3 <= dp_sum;
            if (en_fk)    dp_fk    <= dp_sum;
            if (en_yk)    dp_yk    <= dp_sum;
            if (en_shift) begin
                dp_fk2 <= dp_fk1;
                dp_fk1 <= dp_fk;
            end
        end
    end

    // Every-cycle invariants
    always @(negedge clk) begin
        n_checks++;
        if ($countones({en_acum1, en_acum2, en_acum3, en_fk, en_yk}) > 1) begin
            n_fail++;
            $display("FAIL onehot_enables t=%0t actual=%b required=at most one high", $time,
                     {en_acum1, en_acum2, en_acum3, en_fk, en_yk});
        end
        n_checks++;
        if (busy !== ((controlS != 3'b000) || (controlZ != 3'b000))) begin
            n_fail++;
            $display("FAIL busy_vs_state t=%0t actual=%b required=%b", $time, busy,
                     (controlS != 3'b000) || (controlZ != 3'b000));
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        #1;
        n_checks++;
        if (act !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_outputs actual=%h required=%h", act, 17'h0);
        end
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (act !== 17'h0) begin
                n_fail++;
                $display("FAIL reset_hold_start actual=%h required=%h", act, 17'h0);
            end
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (act !== exp_vec(0, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_release_idle actual=%h required=%h", act, exp_vec(0, 1'b0));
        end
    endtask

    task automatic test_single();
        logic [16:0] e;
        int ndone = 0;
        start = 1'b1;
        for (int s = 1; s <= 7; s++) exp_q.push_back(exp_vec(s, 1'b0));
        exp_q.push_back(exp_vec(0, 1'b0));
        exp_q.push_back(exp_vec(0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            e = exp_q.pop_front();
            if (done) ndone++;
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL single_seq cycle=%0d actual=%h required=%h", i, act, e);
            end
            @(negedge clk);
        end
        n_checks++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL single_done_count actual=%0d required=1", ndone);
        end
    endtask

    task automatic test_overrun();
        logic [16:0] e;
        int ndone = 0;
        start = 1'b1;
        for (int s = 1; s <= 7; s++) exp_q.push_back(exp_vec(s, s == 4));
        exp_q.push_back(exp_vec(0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            if (done) ndone++;
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL overrun_seq cycle=%0d actual=%h required=%h", i, act, e);
            end
            start = (i == 2);
            @(negedge clk);
        end
        n_checks++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL overrun_done_count actual=%0d required=1", ndone);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        int st = 0;
        int prev = 0;
        int ndone = 0;
        int nov = 0;
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            prev = st;
            st = (prev == 0) ? 1 : ((prev == 7) ? 0 : prev + 1);
            exp_q.push_back(exp_vec(st, prev != 0));
            @(negedge clk);
            if (k == 39) start = 1'b0;
            e = exp_q.pop_front();
            if (done) ndone++;
            if (overrun) nov++;
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL b2b_cycle k=%0d actual=%h required=%h", k, act, e);
            end
        end
        n_checks++;
        if (ndone != 5) begin
            n_fail++;
            $display("FAIL b2b_done_count actual=%0d required=5", ndone);
        end
        n_checks++;
        if (nov != 35) begin
            n_fail++;
            $display("FAIL b2b_overrun_count actual=%0d required=35", nov);
        end
        @(negedge clk);
        n_checks++;
        if (act !== exp_vec(0, 1'b0)) begin
            n_fail++;
            $display("FAIL b2b_final_idle actual=%h required=%h", act, exp_vec(0, 1'b0));
        end
    endtask

    task automatic test_closed_loop();
        int rfk, rfk1, rfk2, ryk, wait_n, got;
        rfk1 = 0;
        rfk2 = 0;
        dp_clr = 1'b1;
        @(negedge clk);
        dp_clr = 1'b0;
        for (int n = 0; n < 200; n++) begin
            rfk = uk + q14(a1, rfk1) + q14(a2, rfk2);
            ryk = q14(b0, rfk) + q14(b1, rfk1) + q14(b2, rfk2);
            rfk2 = rfk1;
            rfk1 = rfk;
            yk_q.push_back(ryk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_n = 0;
            while (!done && wait_n < 12) begin
                @(negedge clk);
                wait_n++;
            end
            if (!done) begin
                n_checks++;
                n_fail++;
                $display("FAIL closed_loop_done_timeout sample=%0d actual=no done required=done within 12 cycles", n);
                void'(yk_q.pop_front());
            end else begin
                @(negedge clk);
                got = yk_q.pop_front();
                n_checks++;
                if (dp_yk !== got) begin
                    n_fail++;
                    $display("FAIL closed_loop_yk sample=%0d actual=%0d required=%0d", n, dp_yk, got);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [16:0] e;
        int ndone = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (act !== exp_vec(5, 1'b0)) begin
            n_fail++;
            $display("FAIL areset_in_s5 actual=%h required=%h", act, exp_vec(5, 1'b0));
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (act !== 17'h0) begin
            n_fail++;
            $display("FAIL areset_immediate actual=%h required=%h", act, 17'h0);
        end
        @(negedge clk);
        n_checks++;
        if (act !== 17'h0) begin
            n_fail++;
            $display("FAIL areset_held actual=%h required=%h", act, 17'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (act !== exp_vec(0, 1'b0)) begin
            n_fail++;
            $display("FAIL areset_release_idle actual=%h required=%h", act, exp_vec(0, 1'b0));
        end
        start = 1'b1;
        for (int s = 1; s <= 7; s++) exp_q.push_back(exp_vec(s, 1'b0));
        exp_q.push_back(exp_vec(0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            if (done) ndone++;
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL areset_resume cycle=%0d actual=%h required=%h", i, act, e);
            end
            @(negedge clk);
        end
        n_checks++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL areset_done_count actual=%0d required=1", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_back_to_back();
        test_closed_loop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pb200.md
CTRL_PB200 -- requirements
Module: ctrl_pb200

Interface
REQ-001 SHALL have parameter NSTEP, default 7, meaning the number of compute states per sample; only 7 is supported.
REQ-002 SHALL have port clk, input, 1 bit: system clock; every register updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: new-sample strobe; Uk is valid while start is high.
REQ-005 SHALL have port controlS, output, 3 bits: coefficient select (000 zero, 001 a1, 010 a2, 011 b0, 100 b1, 101 b2).
REQ-006 SHALL have port controlC, output, 2 bits: state-variable select (00 zero, 01 fk1, 10 fk2, 11 fk).
REQ-007 SHALL have port controlZ, output, 3 bits: addend select (000 zero, 001 Uk, 010 yk, 011 acum1, 100 acum2, 101 acum3).
REQ-008 SHALL have ports en_acum1, en_acum2 and en_acum3, outputs, 1 bit each: load the corresponding accumulator with the adder result (muxS*muxC + muxZ).
REQ-009 SHALL have port en_fk, output, 1 bit: load fk from the adder result.
REQ-010 SHALL have port en_shift, output, 1 bit: fk2<=fk1 and fk1<=fk.
REQ-011 SHALL have port en_yk, output, 1 bit: load yk from the adder result.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when yk is being loaded.
REQ-014 SHALL have port overrun, output, 1 bit: one-cycle pulse when start arrives while busy.

Function
REQ-015 SHALL be a Moore FSM with states IDLE, S1 to S7; every control and enable output SHALL be decoded from the registered state only.
REQ-016 In IDLE, start=1 at a rising edge SHALL move the FSM to S1; start=0 SHALL keep it in IDLE.
REQ-017 S1 to S7 SHALL advance unconditionally one state per clock, and S7 SHALL return to IDLE.
REQ-018 Per-state outputs SHALL be, as (S,C,Z; enables):
- IDLE = (000,00,000; none)
- S1 = (001,01,001; en_acum1), computing Uk+a1*fk1
- S2 = (010,10,011; en_acum2), computing acum1+a2*fk2
- S3 = (000,00,100; en_fk), computing fk<=acum2
- S4 = (011,11,000; en_acum1), computing b0*fk
- S5 = (100,01,011; en_acum2), computing acum1+b1*fk1
- S6 = (101,10,100; en_acum3), computing acum2+b2*fk2
- S7 = (000,00,101; en_yk, en_shift, done)
REQ-019 Unused codes (S 110/111, Z 110/111) SHALL never be driven.
REQ-020 Latency: with start sampled at edge 0, done SHALL be high between edges 6 and 7, and yk, fk1 and fk2 SHALL update at edge 7; the sample period SHALL be at least 8 cycles.
REQ-021 A start asserted in S1 to S7 SHALL be ignored for sequencing and SHALL pulse overrun for exactly one cycle per edge at which it is sampled.
REQ-022 A start held high continuously SHALL launch a new sequence at each return to IDLE: one IDLE cycle, then S1.
REQ-023 Exactly one accumulator, fk or yk enable SHALL be high in any state, except S7, where en_yk and en_shift are both high.
REQ-024 The FSM SHALL have no path to an undefined state; any illegal encoding SHALL go to IDLE on the next edge with all enables low.

Reset
REQ-025 While reset is high, the FSM SHALL be in IDLE, and controlS, controlC and controlZ SHALL be 0.
REQ-026 While reset is high, all enables, busy, done and overrun SHALL be 0, independent of clk.
REQ-027 Reset asserted mid-sequence SHALL abort it immediately: no further enables and no done pulse.
REQ-028 After reset is released, the first start SHALL begin at S1 on the following edge.

Verification
REQ-029 Single start pulse -> S/C/Z sequence 001/01/001, 010/10/011, 000/00/100, 011/11/000, 100/01/011, 101/10/100, 000/00/101, then IDLE; done high only in the 7th cycle.
REQ-030 Closed loop with datapath, Uk=1.0 step held for 200 samples -> yk matches a bit-exact fixed-point reference model of fk=Uk+a1*fk1+a2*fk2, yk=b0*fk+b1*fk1+b2*fk2.
REQ-031 start pulsed again in S3 -> overrun high for 1 cycle, sequence unchanged, exactly one done.
REQ-032 start tied high for 40 cycles -> done pulses every 8 cycles, 5 pulses total, overrun pulses at each busy-cycle edge.
REQ-033 reset asserted asynchronously during S5 -> all outputs 0 before the next edge; after release and a new start, a full correct sequence with no stale enables.
REQ-034 Every cycle -> assertion that at most one of en_acum1, en_acum2, en_acum3, en_fk and en_yk is high, and that busy equals (state != IDLE).
